seg7_result_display: RTL
========================

Name: seg7_result_display

Overview:
Display back-end that turns the classifier's 4-bit result into the 7-segment pattern on uo_out[6:0] of tt_um_template.
- Accepts one result per valid/ready handshake.
- Shows the result for a fixed hold time, blanks briefly, then keeps showing the last result until the next one arrives.
- Sits directly between the inference core's result register and the top-level uo_out pins.

Parameters:
HOLD_CYCLES, 10_000_000, cycles a newly accepted digit is shown before another is accepted (>=1)
GAP_CYCLES, 1_000_000, cycles of blank display after the hold (0 = no gap)
LAMP_CYCLES, 5_000_000, length of the lamp test after reset (used only with SEG7_LAMP_TEST_EN, >=1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_digit is valid
in_digit  input  4  result code 0x0-0xF
in_ready  output  1  block can accept a digit this cycle
busy  output  1  high in every state except IDLE
segments  output  7  active-high segment drive; bit0=a ... bit6=g

Behaviour:
- States: IDLE, SHOW, GAP (plus LAMP when SEG7_LAMP_TEST_EN is defined). State, counter, segments and last_digit are all registered.
- Reset (sampled on a clk edge while rst=1): state=IDLE, segments=7'h00, last_digit_valid=0, counter=0.
- While rst=1: in_ready=0 and busy=0, regardless of state.
- in_ready = (state==IDLE) and not rst. busy = (state!=IDLE).
- Handshake: a transfer occurs on a clk edge with in_valid and in_ready both high. in_valid is ignored when in_ready=0; nothing is queued.
- On transfer:
  - last_digit <= in_digit; last_digit_valid <= 1.
  - state <= SHOW; counter <= HOLD_CYCLES-1.
  - segments <= decode(in_digit), visible on the cycle after the transfer (1-cycle latency).
- SHOW:
  - segments hold decode(last_digit); counter decrements each cycle.
  - When counter==0: if GAP_CYCLES>0, go to GAP with counter <= GAP_CYCLES-1 and segments <= 0; otherwise go to IDLE.
  - Total time in SHOW is exactly HOLD_CYCLES cycles.
- GAP:
  - segments=0; counter decrements each cycle.
  - When counter==0: go to IDLE with segments <= decode(last_digit).
  - Total time in GAP is exactly GAP_CYCLES cycles.
- IDLE: segments = decode(last_digit) if last_digit_valid, else 7'h00.
- Decode table (hex glyphs): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Counter width = $clog2(max(HOLD_CYCLES, GAP_CYCLES, LAMP_CYCLES)+1). The counter never wraps.
- Reset mid-operation: the next edge with rst=1 forces the reset values and discards any display in progress.
- Simultaneous events: in the cycle IDLE is entered, in_ready is not yet high. The first transfer can occur one cycle after the last SHOW/GAP cycle.

Optional Feature:
SEG7_LAMP_TEST_EN
- Defined: the reset state is LAMP instead of IDLE.
  - segments=7'h7F, busy=1, in_ready=0 for LAMP_CYCLES cycles after rst deasserts.
  - Then state goes to IDLE and segments=7'h00.
  - Reset values of all other registers are unchanged.
- Undefined: the LAMP state and its logic are absent; behaviour is exactly as above.

Decomposition:
- Package seg7_pkg:
  - state enum (IDLE, SHOW, GAP, LAMP)
  - 16-entry glyph constant array SEG7_GLYPH
  - SEG7_BLANK=7'h00, SEG7_ALL=7'h7F
- Sub-module seg7_hex_decode: combinational, in_digit[3:0] -> seg[6:0], indexes SEG7_GLYPH. It is instantiated once; its output is registered in the parent.

Test Plan:
1. Reset (HOLD=4, GAP=2): hold rst for 3 cycles -> segments=0x00, in_ready=0, busy=0 throughout; in_ready=1 on the first cycle after rst falls.
2. Send 0x3 (HOLD=4, GAP=2) -> segments=0x4F for 4 cycles starting the cycle after transfer, in_ready=0 and busy=1 during them; then 0x00 for 2 cycles; then 0x4F with in_ready=1, busy=0.
3. Sweep codes 0x0-0xF back-to-back (HOLD=1, GAP=0) -> each SHOW cycle matches the glyph table exactly (e.g. 0xB->0x7C, 0xF->0x71).
4. Hold in_valid=1 with 0x5 then 0x9 presented continuously (HOLD=4, GAP=2) -> only 0x5 accepted during SHOW/GAP; 0x9 is accepted on the first IDLE cycle and segments=0x6F on the following cycle.
5. Assert rst during SHOW of 0x8 -> segments=0x00 after that edge; after release, IDLE shows 0x00 (last digit cleared).
6. With SEG7_LAMP_TEST_EN and LAMP=3 -> segments=0x7F, busy=1, in_ready=0 for 3 cycles after reset, then 0x00 with in_ready=1; without the macro -> segments=0x00 and in_ready=1 immediately after reset.

Source files
------------

// File: rtl/seg7_result_display_pkg.sv
// seg7_pkg: shared types and constants for the 7-segment result display.
// Holds the display state encoding, the hex glyph table (bit0=a .. bit6=g,
// active high) and a small helper used to size the shared down-counter.
package seg7_pkg;

  // Display controller states; LAMP is only reachable with SEG7_LAMP_TEST_EN.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2,
    LAMP = 2'd3
  } seg7_state_e;

  localparam logic [6:0] SEG7_BLANK = 7'h00;
  localparam logic [6:0] SEG7_ALL   = 7'h7F;

  // Hex glyphs 0..F, index 0 first. b and d are lower case so they differ
  // from 8 and 0.
  localparam logic [6:0] SEG7_GLYPH [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Largest of three cycle counts; sizes the shared counter so no phase wraps.
  function automatic int seg7_max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/seg7_result_display_hex_decode.sv
// seg7_hex_decode: purely combinational 4-bit code to 7-segment glyph lookup.
// The parent registers the result, so this block adds no latency of its own.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] in_digit,
  output logic [6:0] seg
);

  // Table lookup of the glyph for the presented code.
  always_comb begin
    seg = SEG7_GLYPH[in_digit];
  end

endmodule

// File: rtl/seg7_result_display.sv
// seg7_result_display: accepts one 4-bit classifier result per valid/ready
// handshake, shows its glyph for HOLD_CYCLES, blanks for GAP_CYCLES, then
// keeps showing the last result until a new one is accepted.
// Optional build macro: SEG7_LAMP_TEST_EN - after reset all segments are lit
// for LAMP_CYCLES cycles (LAMP state) before the display becomes idle.
module seg7_result_display
  import seg7_pkg::*;
#(
  parameter int HOLD_CYCLES = 10_000_000,
  parameter int GAP_CYCLES  = 1_000_000,
  parameter int LAMP_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_digit,
  output logic       in_ready,
  output logic       busy,
  output logic [6:0] segments
);

  // One counter serves every timed phase, sized for the longest of them.
  localparam int CNT_MAX = seg7_max3(HOLD_CYCLES, GAP_CYCLES, LAMP_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam bit               GAP_EN    = (GAP_CYCLES > 0);

`ifdef SEG7_LAMP_TEST_EN
  // Lamp test counts up from the reset value of zero to its last cycle.
  localparam logic [CNT_W-1:0] LAMP_LAST   = CNT_W'(LAMP_CYCLES - 1);
  localparam seg7_state_e      RESET_STATE = LAMP;
  localparam logic [6:0]       RESET_SEG   = SEG7_ALL;
`else
  localparam seg7_state_e      RESET_STATE = IDLE;
  localparam logic [6:0]       RESET_SEG   = SEG7_BLANK;
`endif

  seg7_state_e      state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [6:0]       segments_q, segments_d;
  logic [3:0]       last_digit_q, last_digit_d;
  logic             last_digit_valid_q, last_digit_valid_d;

  logic             ready_s;
  logic             transfer_s;
  logic [3:0]       decode_in_s;
  logic [6:0]       decode_seg_s;

  // Ready only in IDLE and never while reset is applied.
  assign ready_s    = (state_q == IDLE) && !rst;
  assign transfer_s = in_valid && ready_s;

  // On a transfer the incoming code is decoded so the glyph lands one cycle
  // later; otherwise the single decoder serves the stored digit.
  assign decode_in_s = transfer_s ? in_digit : last_digit_q;

  seg7_hex_decode u_hex_decode (
    .in_digit (decode_in_s),
    .seg      (decode_seg_s)
  );

  // Next-state, counter, display and digit-store logic.
  always_comb begin
    state_d            = state_q;
    counter_d          = counter_q;
    segments_d         = segments_q;
    last_digit_d       = last_digit_q;
    last_digit_valid_d = last_digit_valid_q;

    case (state_q)
      IDLE: begin
        if (transfer_s) begin
          last_digit_d       = in_digit;
          last_digit_valid_d = 1'b1;
          state_d            = SHOW;
          counter_d          = HOLD_LOAD;
          segments_d         = decode_seg_s;
        end else begin
          segments_d = last_digit_valid_q ? decode_seg_s : SEG7_BLANK;
        end
      end

      SHOW: begin
        segments_d = decode_seg_s;
        if (counter_q == CNT_ZERO) begin
          if (GAP_EN) begin
            state_d    = GAP;
            counter_d  = GAP_LOAD;
            segments_d = SEG7_BLANK;
          end else begin
            state_d    = IDLE;
            counter_d  = CNT_ZERO;
          end
        end else begin
          counter_d = counter_q - CNT_ONE;
        end
      end

      GAP: begin
        if (counter_q == CNT_ZERO) begin
          state_d    = IDLE;
          counter_d  = CNT_ZERO;
          segments_d = decode_seg_s;
        end else begin
          counter_d  = counter_q - CNT_ONE;
          segments_d = SEG7_BLANK;
        end
      end

`ifdef SEG7_LAMP_TEST_EN
      LAMP: begin
        if (counter_q == LAMP_LAST) begin
          state_d    = IDLE;
          counter_d  = CNT_ZERO;
          segments_d = SEG7_BLANK;
        end else begin
          counter_d  = counter_q + CNT_ONE;
          segments_d = SEG7_ALL;
        end
      end
`endif

      default: begin
        state_d    = IDLE;
        counter_d  = CNT_ZERO;
        segments_d = SEG7_BLANK;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= RESET_STATE;
      counter_q          <= CNT_ZERO;
      segments_q         <= RESET_SEG;
      last_digit_q       <= 4'h0;
      last_digit_valid_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      counter_q          <= counter_d;
      segments_q         <= segments_d;
      last_digit_q       <= last_digit_d;
      last_digit_valid_q <= last_digit_valid_d;
    end
  end

  assign in_ready = ready_s;
  assign busy     = (state_q != IDLE) && !rst;
  assign segments = segments_q;

endmodule
